// File: rtl/norm_pkg.sv
// norm_pkg: shared constants and width helpers for the normalization front end.
//   NGROUPS      : number of mantissa groups counted in parallel in S1.
//   sel_w(n)     : shift-amount width for an n-bit mantissa.
//   grp_w(n)     : bits per group.
//   grp_lzc_w(n) : width of a group-local leading-zero count.
package norm_pkg;
   localparam int NGROUPS = 4;

   function automatic int sel_w(input int n);
      return $clog2(n);
   endfunction

   function automatic int grp_w(input int n);
      return n / NGROUPS;
   endfunction

   function automatic int grp_lzc_w(input int n);
      return $clog2(n / NGROUPS);
   endfunction
endpackage

// File: rtl/lzc_group.sv
// lzc_group: combinational leading-zero count of a W-bit vector.
//   i_vec  : input vector, MSB first.
//   o_zero : i_vec is all zeros.
//   o_lzc  : leading zeros (0 when o_zero; the group is then skipped).
module lzc_group #(
   parameter  int W  = 8,
   localparam int LW = $clog2(W)
) (
   input  logic [W-1:0]  i_vec,
   output logic          o_zero,
   output logic [LW-1:0] o_lzc
);
   always_comb begin
      o_zero = ~|i_vec;
      o_lzc  = '0;
      // Walk upward so the highest set bit wins.
      for (int i = 0; i < W; i++)
         if (i_vec[i]) o_lzc = LW'(W - 1 - i);
   end
endmodule

// File: rtl/norm_lzc_stage.sv
// norm_lzc_stage: 2-stage leading-zero count ahead of the barrel shifter.
//   Clock, Reset           : rising-edge clock, async active-high reset.
//   InValid/InReady        : upstream handshake; InReady is combinational
//                            through OutReady.
//   InMant, InExp          : raw sum mantissa and exponent.
//   OutValid/OutReady      : downstream handshake.
//   OutMant                : registered InMant, unshifted.
//   OutShiftAmount, OutExp : left-shift count and adjusted exponent.
//   OutZero, OutUnderflow  : all-zero mantissa / shift clamped to InExp.
module norm_lzc_stage
   import norm_pkg::*;
#(
   parameter int N = 32,
   parameter int E = 8
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 InValid,
   output logic                 InReady,
   input  logic [N-1:0]         InMant,
   input  logic [E-1:0]         InExp,
   output logic                 OutValid,
   input  logic                 OutReady,
   output logic [N-1:0]         OutMant,
   output logic [$clog2(N)-1:0] OutShiftAmount,
   output logic [E-1:0]         OutExp,
   output logic                 OutZero,
   output logic                 OutUnderflow
);
   localparam int nSel = sel_w(N);
   localparam int GW   = grp_w(N);
   localparam int GLW  = grp_lzc_w(N);
   // Compare width wide enough for both LZC and exponent, plus headroom.
   localparam int CW   = ((E > nSel) ? E : nSel) + 1;

   // S1 payload; widths follow N and E so the type lives with the module.
   typedef struct packed {
      logic [N-1:0]                      mant;
      logic [E-1:0]                      exp;
      logic [NGROUPS-1:0]                gzero;
      logic [NGROUPS-1:0][GLW-1:0]       glzc;
   } s1_t;

   logic                        w_s2_load, w_s1_load;
   logic [NGROUPS-1:0]          w_gzero;
   logic [NGROUPS-1:0][GLW-1:0] w_glzc;
   s1_t                         w_s1_next;

   logic                        r_s1_vld, r_s2_vld;
   s1_t                         r_s1;
   logic [N-1:0]                r_mant;
   logic [nSel-1:0]             r_shift;
   logic [E-1:0]                r_exp;
   logic                        r_zero, r_unf;

   // Group g = NGROUPS-1 covers the mantissa MSBs.
   for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
      lzc_group #(.W(GW)) u_grp (
         .i_vec  (InMant[g*GW +: GW]),
         .o_zero (w_gzero[g]),
         .o_lzc  (w_glzc[g])
      );
   end

   always_comb begin
      w_s1_next.mant  = InMant;
      w_s1_next.exp   = InExp;
      w_s1_next.gzero = w_gzero;
      w_s1_next.glzc  = w_glzc;
   end

   // S2 combine: first nonzero group from the top decides the count.
   logic [nSel-1:0] w_lzc, w_shift;
   logic [CW-1:0]   w_lzc_c, w_exp_c;
   logic [E-1:0]    w_exp_out;
   logic            w_allz, w_unf;

   always_comb begin
      w_lzc = '0;
      for (int g = 0; g < NGROUPS; g++)
         if (!r_s1.gzero[g])
            w_lzc = nSel'((NGROUPS - 1 - g) * GW) + nSel'(r_s1.glzc[g]);
      w_allz    = &r_s1.gzero;
      w_lzc_c   = CW'(w_lzc);
      w_exp_c   = CW'(r_s1.exp);
      w_unf     = !w_allz && (w_lzc_c > w_exp_c);
      w_shift   = w_allz ? '0 : (w_unf ? w_exp_c[nSel-1:0] : w_lzc);
      w_exp_out = (w_allz || w_unf) ? '0 : E'(w_exp_c - w_lzc_c);
   end

   assign w_s2_load = !r_s2_vld || OutReady;
   assign w_s1_load = !r_s1_vld || w_s2_load;
   assign InReady   = w_s1_load;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_s1_vld <= 1'b0;
         r_s2_vld <= 1'b0;
         r_s1     <= '0;
         r_mant   <= '0;
         r_shift  <= '0;
         r_exp    <= '0;
         r_zero   <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         if (w_s2_load) begin
            r_s2_vld <= r_s1_vld;
            // Outputs only change when a real item moves in.
            if (r_s1_vld) begin
               r_mant  <= r_s1.mant;
               r_shift <= w_shift;
               r_exp   <= w_exp_out;
               r_zero  <= w_allz;
               r_unf   <= w_unf;
            end
         end
         if (w_s1_load) begin
            r_s1_vld <= InValid;
            if (InValid) r_s1 <= w_s1_next;
         end
      end
   end

   assign OutValid       = r_s2_vld;
   assign OutMant        = r_mant;
   assign OutShiftAmount = r_shift;
   assign OutExp         = r_exp;
   assign OutZero        = r_zero;
   assign OutUnderflow   = r_unf;
endmodule

// File: tb/tb_norm_lzc_stage.sv
module tb_norm_lzc_stage;
   logic        Clock, Reset, InValid, InReady, OutValid, OutReady;
   logic [31:0] InMant, OutMant;
   logic [7:0]  InExp, OutExp;
   logic [4:0]  OutShiftAmount;
   logic        OutZero, OutUnderflow;

   int n_cmp = 0;
   int n_err = 0;

   norm_lzc_stage #(.N(32), .E(8)) dut (
      .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
      .InMant(InMant), .InExp(InExp), .OutValid(OutValid), .OutReady(OutReady),
      .OutMant(OutMant), .OutShiftAmount(OutShiftAmount), .OutExp(OutExp),
      .OutZero(OutZero), .OutUnderflow(OutUnderflow)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct packed {
      logic [31:0] mant;
      logic [4:0]  shift;
      logic [7:0]  exp;
      logic        zero;
      logic        unf;
   } res_t;

   // Reference: count zeros from the top, then apply the exponent rules.
   function automatic res_t model(input logic [31:0] m, input logic [7:0] e);
      res_t r;
      int   lz;
      r = '0;
      r.mant = m;
      lz = 0;
      while (lz < 32 && !m[31 - lz]) lz++;
      if (m == 32'd0) r.zero = 1'b1;
      else if (lz <= int'(e)) begin
         r.shift = 5'(lz);
         r.exp   = 8'(int'(e) - lz);
      end else begin
         r.shift = e[4:0];
         r.unf   = 1'b1;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   function automatic res_t dut_res();
      return {OutMant, OutShiftAmount, OutExp, OutZero, OutUnderflow};
   endfunction

   // Compare process: sampled on the falling edge, when everything is settled.
   res_t q[$];
   res_t held;
   logic prev_stall = 1'b0;
   always @(negedge Clock) begin
      if (Reset) begin
         q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && OutValid) chk("stall_hold", dut_res(), held);
         if (OutValid && OutReady) begin
            if (q.size() == 0) chk("unexpected_out", 1, 0);
            else begin
               res_t w;
               logic [31:0] sh;
               w = q.pop_front();
               chk("out_item", dut_res(), w);
               if (!OutZero && !OutUnderflow) begin
                  sh = OutMant << OutShiftAmount;
                  chk("shifter_msb", sh[31], 1);
               end
            end
         end
         prev_stall = OutValid && !OutReady;
         held = dut_res();
         if (InValid && InReady) q.push_back(model(InMant, InExp));
      end
   end

   task automatic send_one(input logic [31:0] m, input logic [7:0] e,
                           input logic [4:0] sh, input logic [7:0] ex,
                           input logic z, input logic u);
      int lat;
      @(posedge Clock); #1;
      InValid = 1'b1; InMant = m; InExp = e; OutReady = 1'b1;
      lat = 0;
      while (lat < 10) begin
         @(posedge Clock); lat++;
         #1 InValid = 1'b0;
         @(negedge Clock);
         if (OutValid) break;
      end
      chk("latency", 64'(lat), 2);
      chk("mant", OutMant, m);
      chk("shift", OutShiftAmount, sh);
      chk("exp", OutExp, ex);
      chk("zero", OutZero, z);
      chk("unf", OutUnderflow, u);
   endtask

   logic [31:0] sv_m [6] = '{32'h0000_1234, 32'h8000_0000, 32'h0000_0001,
                             32'h0000_0000, 32'h0040_0000, 32'h0000_FFFF};
   logic [7:0]  sv_e [6] = '{8'd40, 8'd5, 8'd10, 8'd77, 8'd9, 8'd200};

   initial begin
      int idx, bubbles, acc, cyc;
      logic saw_drop;
      Reset = 1'b0; InValid = 1'b0; InMant = '0; InExp = '0; OutReady = 1'b0;
      #1 Reset = 1'b1;
      #1;
      chk("rst_valid", OutValid, 0);
      chk("rst_outs", dut_res(), 0);
      repeat (2) @(posedge Clock);
      #1 Reset = 1'b0;

      // Directed, hand-computed.
      send_one(32'h0000_1234, 8'd40, 5'd19, 8'd21, 1'b0, 1'b0);
      send_one(32'h8000_0000, 8'd5,  5'd0,  8'd5,  1'b0, 1'b0);
      send_one(32'h0080_0000, 8'd8,  5'd8,  8'd0,  1'b0, 1'b0);
      send_one(32'h0000_0001, 8'd10, 5'd10, 8'd0,  1'b0, 1'b1);
      send_one(32'h0000_0000, 8'd77, 5'd0,  8'd0,  1'b1, 1'b0);

      // Stream of 6 with a 3-cycle downstream stall.
      idx = 0; bubbles = 0; saw_drop = 1'b0;
      for (cyc = 0; cyc < 20; cyc++) begin
         @(posedge Clock); #1;
         OutReady = !(cyc >= 3 && cyc <= 5);
         InValid  = (idx < 6);
         InMant   = sv_m[idx % 6];
         InExp    = sv_e[idx % 6];
         @(negedge Clock);
         if (!InReady && !OutReady) saw_drop = 1'b1;
         if (InValid && OutReady && !InReady) bubbles++;
         if (InValid && InReady) idx++;
      end
      chk("stream_inready_drop", saw_drop, 1);
      chk("stream_no_bubble", 64'(bubbles), 0);
      chk("stream_all_in", 64'(idx), 6);
      chk("stream_drained", 64'(q.size()), 0);

      // Async reset with two items in flight.
      @(posedge Clock); #1;
      InValid = 1'b1; InMant = 32'h0000_00F0; InExp = 8'd50; OutReady = 1'b0;
      @(posedge Clock); #1 InMant = 32'h0F00_0000;
      @(posedge Clock); #1 InValid = 1'b0;
      chk("pre_rst_valid", OutValid, 1);
      #2 Reset = 1'b1;
      #1;
      chk("async_rst_valid", OutValid, 0);
      chk("async_rst_outs", dut_res(), 0);
      @(negedge Clock);
      @(posedge Clock); #1 Reset = 1'b0;
      send_one(32'h0000_4000, 8'd100, 5'd17, 8'd83, 1'b0, 1'b0);

      // Random regression.
      acc = 0; cyc = 0;
      while (acc < 10000 && cyc < 60000) begin
         @(posedge Clock); #1;
         InValid  = ($urandom_range(0, 3) != 0);
         InMant   = $urandom() >> $urandom_range(0, 32);
         InExp    = 8'($urandom_range(0, 255));
         OutReady = ($urandom_range(0, 3) != 0);
         @(negedge Clock);
         if (InValid && InReady) acc++;
         cyc++;
      end
      chk("rand_accepted", 64'(acc), 10000);
      @(posedge Clock); #1 InValid = 1'b0; OutReady = 1'b1;
      repeat (6) @(posedge Clock);
      @(negedge Clock);
      chk("rand_drained", 64'(q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
